// File: rtl/prio_fifo_param_if.sv
// ---------------------------------------------------------------------------
// prio_fifo_param_if
//   Bus bundle for the deadline-sorted priority FIFO.
//   master : request side (drives we/din/re, observes status and pops)
//   slave  : the FIFO itself
//   Signals:
//     we, din, re                 push/pop requests and push data
//     dout, valid                 registered pop result and its 1-cycle pulse
//     head_key                    key of the current minimum entry (0 if empty)
//     count, full, empty          occupancy status
//     ovf, udf                    1-cycle pulses for lost push / pop on empty
// ---------------------------------------------------------------------------
interface prio_fifo_param_if #(
  parameter int DATA_W = 16,
  parameter int KEY_W  = 16,
  parameter int DEPTH  = 16,
  parameter int CNT_W  = $clog2(DEPTH + 1)
);
  logic              we;
  logic [DATA_W-1:0] din;
  logic              re;
  logic [DATA_W-1:0] dout;
  logic              valid;
  logic [KEY_W-1:0]  head_key;
  logic [CNT_W-1:0]  count;
  logic              full;
  logic              empty;
  logic              ovf;
  logic              udf;

  modport master (
    output we, din, re,
    input  dout, valid, head_key, count, full, empty, ovf, udf
  );

  modport slave (
    input  we, din, re,
    output dout, valid, head_key, count, full, empty, ovf, udf
  );
endinterface

// File: rtl/prio_fifo_param.sv
// ---------------------------------------------------------------------------
// prio_fifo_param
//   Earliest-deadline-first FIFO. Up to DEPTH entries are held in a sorted
//   shift array; slot 0 always holds the smallest key (key = din[KEY_W-1:0]).
//   Equal keys leave in arrival order. Push and pop may occur in the same
//   cycle; pops appear on dout one cycle after re is sampled.
//
//   Ports:
//     clk   in   single clock, rising edge
//     rst   in   asynchronous active-low reset
//     bus   slave modport of prio_fifo_param_if:
//             we/din/re in; dout/valid/head_key/count/full/empty/ovf/udf out
//
//   Build option:
//     PRIO_FIFO_DROP_EN  when defined, a push into a full FIFO (no pop) whose
//                        key is smaller than the last slot's key evicts that
//                        last (latest-deadline) entry and is inserted sorted.
//                        Otherwise every push into a full FIFO is dropped.
//                        ovf pulses in both cases.
// ---------------------------------------------------------------------------
module prio_fifo_param #(
  parameter int DATA_W = 16,
  parameter int KEY_W  = 16,
  parameter int DEPTH  = 16,
  parameter int CNT_W  = $clog2(DEPTH + 1)
) (
  input logic              clk,
  input logic              rst,
  prio_fifo_param_if.slave bus
);

  // Storage: data is not reset, only the per-slot valid bits are.
  logic [DEPTH-1:0][DATA_W-1:0] slot_data;
  logic [DEPTH-1:0][DATA_W-1:0] slot_nxt;
  logic [DEPTH-1:0]             slot_vld;
  logic [DEPTH-1:0]             slot_vld_nxt;
  logic [CNT_W-1:0]             count_q;
  logic [CNT_W-1:0]             count_nxt;

  // Registered pop result and event pulses.
  logic [DATA_W-1:0] dout_p1;
  logic              vld_p1;
  logic              ovf_p1;
  logic              udf_p1;

  logic [KEY_W-1:0] din_key;
  logic [DEPTH-1:0] le;
  logic             full_w;
  logic             empty_w;
  logic             do_pop;
  logic             push_ok;
  logic             evict;
  logic             ins;
  logic             ovf_nxt;
  logic             udf_nxt;

  // ---- stage p0: request decode and insert-position search ----
  assign din_key = bus.din[KEY_W-1:0];
  assign full_w  = (count_q == CNT_W'(DEPTH));
  assign empty_w = (count_q == '0);

  assign do_pop  = bus.re && !empty_w;
  // A push into a full FIFO is still accepted when a pop frees a slot.
  assign push_ok = bus.we && (!full_w || bus.re);
  assign ovf_nxt = bus.we && full_w && !bus.re;
  assign udf_nxt = bus.re && empty_w;

`ifdef PRIO_FIFO_DROP_EN
  // Full means slot DEPTH-1 is valid, so !le there is "new key < last key".
  assign evict = ovf_nxt && !le[DEPTH-1];
`else
  assign evict = 1'b0;
`endif

  assign ins = push_ok || evict;

  // le[j]: slot j is valid and sorts ahead of (or ties with) the new entry.
  // Because the array is sorted and valid slots are contiguous, le is a
  // thermometer code; its popcount is the insert position.
  for (genvar j = 0; j < DEPTH; j++) begin : g_le
    assign le[j] = slot_vld[j] && (slot_data[j][KEY_W-1:0] <= din_key);
  end

  // Per-slot next value. Three moves exist:
  //   push only  : slots at/after the insert point shift up, din fills the gap
  //   pop only   : everything shifts down
  //   push + pop : slot 0 leaves; slots that sort ahead of din shift down,
  //                din lands in the first slot whose upper neighbour does not,
  //                later slots stay in place
  for (genvar j = 0; j < DEPTH; j++) begin : g_slot
    logic [DATA_W-1:0] above;
    logic [DATA_W-1:0] below;
    logic              le_above;
    logic              le_below;
    logic              le_self;

    if (j < DEPTH - 1) begin : g_above
      assign above    = slot_data[j+1];
      assign le_above = le[j+1];
    end else begin : g_above
      assign above    = slot_data[j];
      assign le_above = 1'b0;
    end

    if (j > 0) begin : g_below
      assign below    = slot_data[j-1];
      assign le_below = le[j-1];
      assign le_self  = le[j];
    end else begin : g_below
      assign below    = slot_data[j];
      assign le_below = 1'b1;
      assign le_self  = 1'b1;
    end

    assign slot_nxt[j] =
      (ins && do_pop) ? (le_above ? above : (le_self ? bus.din : slot_data[j])) :
      ins             ? (le[j] ? slot_data[j] : (le_below ? bus.din : below)) :
      do_pop          ? above :
                        slot_data[j];

    assign slot_vld_nxt[j] = (count_nxt > CNT_W'(j));
  end

  always_comb begin
    count_nxt = count_q;
    if (push_ok && !do_pop) begin
      count_nxt = count_q + CNT_W'(1);
    end else if (do_pop && !push_ok) begin
      count_nxt = count_q - CNT_W'(1);
    end
  end

  // ---- stage p1: array update and registered outputs ----
  always_ff @(posedge clk) begin
    slot_data <= slot_nxt;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      slot_vld <= '0;
      count_q  <= '0;
      dout_p1  <= '0;
      vld_p1   <= 1'b0;
      ovf_p1   <= 1'b0;
      udf_p1   <= 1'b0;
    end else begin
      slot_vld <= slot_vld_nxt;
      count_q  <= count_nxt;
      vld_p1   <= do_pop;
      ovf_p1   <= ovf_nxt;
      udf_p1   <= udf_nxt;
      if (do_pop) begin
        dout_p1 <= slot_data[0];
      end
    end
  end

  assign bus.dout     = dout_p1;
  assign bus.valid    = vld_p1;
  assign bus.ovf      = ovf_p1;
  assign bus.udf      = udf_p1;
  assign bus.count    = count_q;
  assign bus.full     = full_w;
  assign bus.empty    = empty_w;
  assign bus.head_key = slot_vld[0] ? slot_data[0][KEY_W-1:0] : '0;

endmodule

// File: tb/tb_prio_fifo_param.sv
module tb_prio_fifo_param;
  localparam int DATA_W = 16;
  localparam int KEY_W  = 8;
  localparam int DEPTH  = 16;
  localparam int CNT_W  = $clog2(DEPTH + 1);

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  prio_fifo_param_if #(.DATA_W(DATA_W), .KEY_W(KEY_W), .DEPTH(DEPTH)) bus ();

  prio_fifo_param #(.DATA_W(DATA_W), .KEY_W(KEY_W), .DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  logic [DATA_W-1:0] mq[$];      // reference contents, sorted
  logic [DATA_W-1:0] exp_q[$];   // scoreboard of expected pops
  logic [DATA_W-1:0] got_q[$];   // popped values seen, for directed checks
  logic [DATA_W-1:0] last_dout;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic void m_insert(input logic [DATA_W-1:0] d);
    int p = 0;
    foreach (mq[i]) if (mq[i][KEY_W-1:0] <= d[KEY_W-1:0]) p++;
    mq.insert(p, d);
  endfunction

  function automatic void m_clear();
    mq.delete();
    exp_q.delete();
    last_dout = '0;
  endfunction

  task automatic cycle(input logic w, input logic [DATA_W-1:0] d, input logic r);
    logic e_ovf, e_udf, e_vld;
    logic [DATA_W-1:0] e;
    bus.we = w; bus.din = d; bus.re = r;
    e_ovf = 1'b0; e_udf = 1'b0; e_vld = 1'b0;
    if (r && mq.size() != 0) begin
      e_vld = 1'b1;
      exp_q.push_back(mq.pop_front());
    end else if (r) begin
      e_udf = 1'b1;
    end
    if (w) begin
      if (mq.size() < DEPTH) m_insert(d);
      else begin
        e_ovf = 1'b1;
`ifdef PRIO_FIFO_DROP_EN
        if (d[KEY_W-1:0] < mq[DEPTH-1][KEY_W-1:0]) begin
          void'(mq.pop_back());
          m_insert(d);
        end
`endif
      end
    end
    @(posedge clk); #1;
    bus.we = 1'b0; bus.re = 1'b0;
    check("valid", 32'(bus.valid), 32'(e_vld));
    check("ovf", 32'(bus.ovf), 32'(e_ovf));
    check("udf", 32'(bus.udf), 32'(e_udf));
    if (bus.valid && exp_q.size() != 0) begin
      e = exp_q.pop_front();
      check("dout", 32'(bus.dout), 32'(e));
      last_dout = e;
      got_q.push_back(bus.dout);
    end else begin
      check("dout_hold", 32'(bus.dout), 32'(last_dout));
    end
    check("count", 32'(bus.count), 32'(mq.size()));
    check("empty", 32'(bus.empty), 32'(mq.size() == 0));
    check("full", 32'(bus.full), 32'(mq.size() == DEPTH));
    check("head_key", 32'(bus.head_key),
          (mq.size() != 0) ? 32'(mq[0][KEY_W-1:0]) : 32'd0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [DATA_W-1:0] pushes [5];
    logic [DATA_W-1:0] order  [5];
    logic [DATA_W-1:0] d0;
    logic              seen115;

    bus.we = 1'b0; bus.re = 1'b0; bus.din = '0;
    rst = 1'b0;
    m_clear();
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;

    // Reset state
    check("rst_count", 32'(bus.count), 32'd0);
    check("rst_empty", 32'(bus.empty), 32'd1);
    check("rst_full", 32'(bus.full), 32'd0);
    check("rst_valid", 32'(bus.valid), 32'd0);
    check("rst_dout", 32'(bus.dout), 32'd0);
    check("rst_head", 32'(bus.head_key), 32'd0);
    check("rst_ovf", 32'(bus.ovf), 32'd0);
    check("rst_udf", 32'(bus.udf), 32'd0);

    // Sorted order with ties; upper byte tags the arrival of the two key-10 entries
    pushes = '{16'h0032, 16'h010A, 16'h00C8, 16'h020A, 16'h0004};
    order  = '{16'h0004, 16'h010A, 16'h020A, 16'h0032, 16'h00C8};
    foreach (pushes[i]) begin
      cycle(1'b1, pushes[i], 1'b0);
      repeat (10) cycle(1'b0, '0, 1'b0);
    end
    check("t1_count5", 32'(bus.count), 32'd5);
    got_q.delete();
    repeat (5) cycle(1'b0, '0, 1'b1);
    check("t1_npops", 32'(got_q.size()), 32'd5);
    foreach (order[i]) if (i < got_q.size()) check("t1_order", 32'(got_q[i]), 32'(order[i]));
    check("t1_empty", 32'(bus.empty), 32'd1);

    // Fill, then push into full
    for (int k = 100; k <= 115; k++) cycle(1'b1, 16'(k), 1'b0);
    check("t2_full", 32'(bus.full), 32'd1);
    cycle(1'b1, 16'd3, 1'b0);
    check("t2_ovf", 32'(bus.ovf), 32'd1);
    check("t2_count", 32'(bus.count), 32'd16);
    cycle(1'b0, '0, 1'b1);
`ifdef PRIO_FIFO_DROP_EN
    check("t2_pop", 32'(bus.dout), 32'd3);
`else
    check("t2_pop", 32'(bus.dout), 32'd100);
`endif

    // Full queue, simultaneous push and pop
    cycle(1'b1, 16'd120, 1'b0);
    check("t3_full", 32'(bus.full), 32'd1);
    cycle(1'b1, 16'd7, 1'b1);
`ifdef PRIO_FIFO_DROP_EN
    check("t3_head_out", 32'(bus.dout), 32'd100);
`else
    check("t3_head_out", 32'(bus.dout), 32'd101);
`endif
    check("t3_count", 32'(bus.count), 32'd16);
    cycle(1'b0, '0, 1'b1);
    check("t3_pop7", 32'(bus.dout), 32'd7);
    seen115 = 1'b0;
    repeat (15) begin
      cycle(1'b0, '0, 1'b1);
      if (bus.dout[KEY_W-1:0] == 8'd115) seen115 = 1'b1;
    end
    check("t3_drained", 32'(bus.empty), 32'd1);
`ifdef PRIO_FIFO_DROP_EN
    check("t3_seen115", 32'(seen115), 32'd0);
`else
    check("t3_seen115", 32'(seen115), 32'd1);
`endif

    // Empty queue, simultaneous push and pop
    d0 = bus.dout;
    cycle(1'b1, 16'd20, 1'b1);
    check("t4_udf", 32'(bus.udf), 32'd1);
    check("t4_valid", 32'(bus.valid), 32'd0);
    check("t4_count", 32'(bus.count), 32'd1);
    check("t4_head", 32'(bus.head_key), 32'd20);
    check("t4_dout", 32'(bus.dout), 32'(d0));
    cycle(1'b0, '0, 1'b1);
    check("t4_pop20", 32'(bus.dout), 32'd20);

    // Pop on empty held for 3 cycles
    d0 = bus.dout;
    repeat (3) begin
      cycle(1'b0, '0, 1'b1);
      check("t5_udf", 32'(bus.udf), 32'd1);
      check("t5_valid", 32'(bus.valid), 32'd0);
      check("t5_dout", 32'(bus.dout), 32'(d0));
    end

    // Asynchronous reset mid-cycle
    for (int i = 0; i < 8; i++) cycle(1'b1, 16'(8'd30 + 8'(i)), 1'b0);
    cycle(1'b0, '0, 1'b1);
    #3 rst = 1'b0;
    #1;
    check("t6_count", 32'(bus.count), 32'd0);
    check("t6_empty", 32'(bus.empty), 32'd1);
    check("t6_valid", 32'(bus.valid), 32'd0);
    check("t6_dout", 32'(bus.dout), 32'd0);
    check("t6_head", 32'(bus.head_key), 32'd0);
    m_clear();
    @(negedge clk);
    rst = 1'b1;
    cycle(1'b0, '0, 1'b1);
    check("t6_udf", 32'(bus.udf), 32'd1);

    // Random traffic against the reference model
    for (int i = 0; i < 400; i++) begin
      logic [DATA_W-1:0] rd;
      rd = {8'($urandom_range(0, 255)), 8'($urandom_range(0, 15))};
      cycle(($urandom_range(0, 99) < 60), rd, ($urandom_range(0, 99) < 45));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
